wb_burst_reader: RTL and testbench

WB_BURST_READER -- requirements
Module: wb_burst_reader

---
 rtl/wb_burst_reader.sv | 210 +++++++++++++++++++++
 tb/tb_wb_burst_reader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_reader.sv
// rtl/wb_burst_reader.sv - Wishbone classic burst read master into a stream FIFO; optional bus error support via WB_BURST_READER_ERR_EN
module wb_burst_reader #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [31:0] base_adr,
  input  logic [15:0] count,
  output logic        busy,
  output logic        done,
  output logic [31:0] m_adr_o,
  output logic [2:0]  m_cti_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
`ifdef WB_BURST_READER_ERR_EN
  input  logic        m_err_i,
  output logic        err,
`endif
  output logic [31:0] out_dat,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    BURST      = 2'd2,
    DRAIN      = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [15:0] rem_q, rem_d;
  logic [4:0]  beats_q, beats_d;
  logic        cyc_q, cyc_d;
  logic [2:0]  cti_q, cti_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   fifo_mem [FIFO_DEPTH];

  logic        bus_err;
  logic        push;
  logic        pop;
  logic [4:0]  burst_l;
  logic [AW:0] fifo_free;

`ifdef WB_BURST_READER_ERR_EN
  assign bus_err = m_err_i;
  assign err     = err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Read-only master: write-side bus signals are constant
  assign m_we_o  = 1'b0;
  assign m_sel_o = 4'hF;
  assign m_dat_o = 32'h0;

  assign m_adr_o   = adr_q;
  assign m_cyc_o   = cyc_q;
  assign m_stb_o   = cyc_q;
  assign m_cti_o   = cti_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = (cnt_q != '0);
  assign out_dat   = fifo_mem[rd_ptr_q];

  // FIFO push/pop qualification and pointer/occupancy next state
  always_comb begin
    push      = (state_q == BURST) && m_ack_i && !bus_err;
    pop       = out_valid && out_ready;
    fifo_free = (AW + 1)'(FIFO_DEPTH) - cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
      2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Transfer sequencing: latch request, wait for FIFO room, run bursts, drain
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    cyc_d   = cyc_q;
    cti_d   = cti_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    burst_l = (rem_q > 16'(BURST_LEN)) ? 5'(BURST_LEN) : rem_q[4:0];

    case (state_q)
      IDLE: begin
        cyc_d = 1'b0;
        cti_d = 3'b000;
        if (start) begin
          err_d = 1'b0;
          if (count != 16'd0) begin
            adr_d   = base_adr & ~32'h3;
            rem_d   = count;
            busy_d  = 1'b1;
            state_d = WAIT_SPACE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_SPACE: begin
        // Only open a burst once the whole burst is guaranteed to fit
        if (32'(fifo_free) >= 32'(burst_l)) begin
          state_d = BURST;
          cyc_d   = 1'b1;
          beats_d = burst_l;
          cti_d   = (burst_l == 5'd1) ? 3'b111 : 3'b010;
        end
      end
      BURST: begin
        if (bus_err) begin
          cyc_d   = 1'b0;
          cti_d   = 3'b000;
          rem_d   = 16'd0;
          err_d   = 1'b1;
          state_d = DRAIN;
        end else if (m_ack_i) begin
          adr_d   = adr_q + 32'd4;
          rem_d   = rem_q - 16'd1;
          beats_d = beats_q - 5'd1;
          if (beats_q == 5'd1) begin
            cyc_d   = 1'b0;
            cti_d   = 3'b000;
            state_d = (rem_q == 16'd1) ? DRAIN : WAIT_SPACE;
          end else begin
            cti_d = (beats_q == 5'd2) ? 3'b111 : 3'b010;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops the bus and empties the FIFO at once
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      adr_q    <= 32'h0;
      rem_q    <= 16'h0;
      beats_q  <= 5'h0;
      cyc_q    <= 1'b0;
      cti_q    <= 3'b000;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      beats_q  <= beats_d;
      cyc_q    <= cyc_d;
      cti_q    <= cti_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= m_dat_i;
    end
  end

endmodule

// File: tb/tb_wb_burst_reader.sv
// tb/tb_wb_burst_reader.sv - self-checking bench for wb_burst_reader
module tb_wb_burst_reader;

  localparam int BL = 8;
  localparam int FD = 16;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start     = 1'b0;
  logic [31:0] base_adr  = 32'h0;
  logic [15:0] count     = 16'h0;
  logic        busy, done;
  logic [31:0] m_adr_o;
  logic [2:0]  m_cti_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_dat_o;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic [31:0] m_dat_i   = 32'h0;
  logic        m_ack_i   = 1'b0;
  logic [31:0] out_dat;
  logic        out_valid;
  logic        out_ready = 1'b1;
`ifdef WB_BURST_READER_ERR_EN
  logic        m_err_i   = 1'b0;
  logic        err;
`endif

  wb_burst_reader #(.BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .start(start), .base_adr(base_adr), .count(count),
    .busy(busy), .done(done),
    .m_adr_o(m_adr_o), .m_cti_o(m_cti_o), .m_sel_o(m_sel_o), .m_dat_o(m_dat_o),
    .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
`ifdef WB_BURST_READER_ERR_EN
    .m_err_i(m_err_i), .err(err),
`endif
    .out_dat(out_dat), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mdl_adr;
  int          mdl_rem, mdl_beat, mdl_len;
  int          acks, bursts, done_cnt, cti_last_cnt, cyc_cycles, words_out;
  bit          slow_slave, expect_cyc_low, prev_cyc;
  int          err_beat = -1;

  typedef struct {
    logic [31:0] base;
    logic [15:0] cnt;
    bit          slow;
    bit          rrand;
    bit          sbusy;
    int          exp_bursts;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a ^ 32'hC3A5_0F0F) + 32'h0001_3579;
  endfunction

  // One clock: pop check before the edge, observation and slave response after it
  task automatic cycle();
    bit pop_now;
    pop_now = out_valid && out_ready && sys_rst_n;
    if (pop_now) begin
      words_out++;
      if (exp_q.size() == 0) check("pop_unexpected", 64'd1, 64'd0);
      else check("out_dat", out_dat, exp_q.pop_front());
    end
    @(posedge sys_clk);
    #1;
    if (expect_cyc_low) begin
      check("cyc_gap", m_cyc_o, 64'd0);
      expect_cyc_low = 1'b0;
    end
    if (done) begin
      done_cnt++;
      check("done_busy", busy, 64'd0);
      check("done_empty", out_valid, 64'd0);
    end
    if (m_cyc_o) begin
      cyc_cycles++;
      check("bus_static", {m_we_o, m_sel_o, m_stb_o, m_dat_o}, {1'b0, 4'hF, 1'b1, 32'h0});
      if (!prev_cyc) begin
        bursts++;
        mdl_len  = (mdl_rem > BL) ? BL : mdl_rem;
        mdl_beat = 0;
        if (mdl_rem == 0) check("spurious_burst", 64'd1, 64'd0);
      end
    end
    m_ack_i = 1'b0;
`ifdef WB_BURST_READER_ERR_EN
    m_err_i = 1'b0;
`endif
    if (m_cyc_o && m_stb_o && (!slow_slave || $urandom_range(0, 1) == 1)) begin
      check("adr", m_adr_o, mdl_adr);
      check("cti", m_cti_o, (mdl_beat == mdl_len - 1) ? 3'b111 : 3'b010);
      if (m_cti_o == 3'b111) cti_last_cnt++;
      m_dat_i = word_of(m_adr_o);
      if (err_beat == acks) begin
`ifdef WB_BURST_READER_ERR_EN
        m_err_i = 1'b1;
`endif
        mdl_rem        = 0;
        expect_cyc_low = 1'b1;
        err_beat       = -1;
      end else begin
        m_ack_i = 1'b1;
        exp_q.push_back(word_of(mdl_adr));
        mdl_adr = mdl_adr + 32'd4;
        mdl_rem--;
        mdl_beat++;
        acks++;
        if (mdl_beat == mdl_len) expect_cyc_low = 1'b1;
      end
    end
    prev_cyc = m_cyc_o;
  endtask

  task automatic setup_model(input logic [31:0] b, input logic [15:0] c);
    mdl_adr        = b & ~32'h3;
    mdl_rem        = int'(c);
    mdl_beat       = 0;
    mdl_len        = 0;
    acks           = 0;
    bursts         = 0;
    done_cnt       = 0;
    cti_last_cnt   = 0;
    cyc_cycles     = 0;
    words_out      = 0;
    expect_cyc_low = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_vector(input logic [31:0] b, input logic [15:0] c, input bit slow,
                            input bit rrand, input bit sbusy, input int exp_bursts,
                            input int exp_words);
    bit had_err;
    had_err    = (err_beat >= 0);
    slow_slave = slow;
    setup_model(b, c);
    start    = 1'b1;
    base_adr = b;
    count    = c;
    cycle();
    start = 1'b0;
    if (c == 16'd0) check("done_next_cycle", done, 64'd1);
    else check("busy_after_start", busy, 64'd1);
    for (int n = 0; n < 600 && done_cnt == 0; n++) begin
      out_ready = rrand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sbusy && n == 3) begin
        start    = 1'b1;
        base_adr = 32'h9000;
        count    = 16'd3;
      end
      cycle();
      start = 1'b0;
    end
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) cycle();
    check("done_once", done_cnt, 64'd1);
    check("bursts", bursts, exp_bursts);
    check("words_out", words_out, exp_words);
    check("q_empty", exp_q.size(), 64'd0);
    check("busy_end", busy, 64'd0);
    if (!had_err) check("cti_last", cti_last_cnt, exp_bursts);
    if (c == 16'd0) check("no_cyc", cyc_cycles, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_1000, 16'd8,  1'b0, 1'b0, 1'b0, 1};
    vecs[1] = '{32'h0000_2002, 16'd20, 1'b0, 1'b0, 1'b1, 3};
    vecs[2] = '{32'hFFFF_FFF8, 16'd5,  1'b1, 1'b0, 1'b0, 1};
    vecs[3] = '{32'h0000_3000, 16'd1,  1'b0, 1'b0, 1'b0, 1};
    vecs[4] = '{32'h0000_4000, 16'd17, 1'b1, 1'b1, 1'b1, 3};
    vecs[5] = '{32'h0000_5000, 16'd0,  1'b0, 1'b0, 1'b0, 0};

    setup_model(32'h0, 16'd0);
    slow_slave = 1'b0;
    prev_cyc   = 1'b0;
    cycle();
    cycle();
    check("rst_busy", busy, 64'd0);
    check("rst_done", done, 64'd0);
    check("rst_cyc", m_cyc_o, 64'd0);
    check("rst_stb", m_stb_o, 64'd0);
    check("rst_cti", m_cti_o, 64'd0);
    check("rst_adr", m_adr_o, 64'd0);
    check("rst_valid", out_valid, 64'd0);
    sys_rst_n = 1'b1;
    cycle();

    for (int i = 0; i < 6; i++) begin
      run_vector(vecs[i].base, vecs[i].cnt, vecs[i].slow, vecs[i].rrand, vecs[i].sbusy,
                 vecs[i].exp_bursts, int'(vecs[i].cnt));
    end

    // Back-pressure: FIFO fills, master parks in WAIT_SPACE, then resumes
    slow_slave = 1'b0;
    setup_model(32'h0000_A000, 16'd40);
    out_ready = 1'b0;
    start     = 1'b1;
    base_adr  = 32'h0000_A000;
    count     = 16'd40;
    cycle();
    start = 1'b0;
    for (int n = 0; n < 60; n++) cycle();
    check("bp_fetched", acks, 64'd16);
    check("bp_cyc_idle", m_cyc_o, 64'd0);
    check("bp_busy", busy, 64'd1);
    check("bp_valid", out_valid, 64'd1);
    check("bp_no_done", done_cnt, 64'd0);
    out_ready = 1'b1;
    for (int n = 0; n < 600 && done_cnt == 0; n++) cycle();
    check("bp_done", done_cnt, 64'd1);
    check("bp_words", words_out, 64'd40);
    check("bp_bursts", bursts, 64'd5);
    check("bp_cti_last", cti_last_cnt, 64'd5);

    // Reset asserted while beat 3 of 8 is on the bus
    setup_model(32'h0000_6000, 16'd8);
    start    = 1'b1;
    base_adr = 32'h0000_6000;
    count    = 16'd8;
    cycle();
    start = 1'b0;
    for (int n = 0; n < 100 && acks < 3; n++) cycle();
    check("rst_reach_beat3", acks, 64'd3);
    sys_rst_n = 1'b0;
    m_ack_i   = 1'b0;
    #1;
    check("midrst_cyc", m_cyc_o, 64'd0);
    check("midrst_stb", m_stb_o, 64'd0);
    check("midrst_valid", out_valid, 64'd0);
    check("midrst_busy", busy, 64'd0);
    exp_q.delete();
    cycle();
    cycle();
    check("midrst_no_done", done_cnt, 64'd0);
    sys_rst_n = 1'b1;
    cycle();
    run_vector(32'h0000_7000, 16'd1, 1'b0, 1'b0, 1'b0, 1, 1);

`ifdef WB_BURST_READER_ERR_EN
    // Bus error on beat 2 of 8, then a clean transfer clears the sticky flag
    err_beat = 1;
    run_vector(32'h0000_8000, 16'd8, 1'b0, 1'b0, 1'b0, 1, 1);
    check("err_set", err, 64'd1);
    err_beat = -1;
    run_vector(32'h0000_8100, 16'd2, 1'b0, 1'b0, 1'b0, 1, 2);
    check("err_cleared", err, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
